// File: rtl/reg_serializer.sv
// Parallel-to-serial readout stage: accepts one word on a valid/ready handshake
// and shifts it onto sout, each bit held DIV clocks, framed by sframe and closed by done.
module reg_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             sframe,
  output logic             done
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q,   state_d;
  logic [WIDTH-1:0]   shift_q,   shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               sout_q,    sout_d;
  logic               sframe_q,  sframe_d;
  logic               done_q,    done_d;

  // Bit presented on the line: the output end of the shift register.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Advance one bit toward the output end, filling with zero.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = SHIFT;
          shift_d   = in_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (div_cnt_q == LAST_DIV) begin
          div_cnt_d = '0;
          shift_d   = shift_one(shift_q);
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = DONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the next state so the first bit appears right after accept.
    sframe_d = (state_d == SHIFT);
    done_d   = (state_d == DONE);
    sout_d   = sframe_d & out_bit(shift_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sout_q    <= 1'b0;
      sframe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sout_q    <= sout_d;
      sframe_q  <= sframe_d;
      done_q    <= done_d;
    end
  end

  // Ready is held low during reset so nothing is accepted on the reset edge.
  assign in_ready = (state_q == IDLE) & ~rst;
  assign sout     = sout_q;
  assign sframe   = sframe_q;
  assign done     = done_q;

endmodule

// File: tb/tb_reg_serializer.sv
// Scoreboard bench for reg_serializer: three instances (MSB-first, LSB-first, DIV=1)
// driven with directed words; a negedge monitor checks every framed bit and done pulse.
module tb_reg_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_valid_r = '0;
  logic [7:0] in_data_r [3];
  logic [2:0] in_ready_w, sout_w, sframe_w, done_w;

  always #5 clk = ~clk;

  reg_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid_r[0]), .in_data(in_data_r[0]),
    .in_ready(in_ready_w[0]), .sout(sout_w[0]), .sframe(sframe_w[0]), .done(done_w[0]));

  reg_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid_r[1]), .in_data(in_data_r[1]),
    .in_ready(in_ready_w[1]), .sout(sout_w[1]), .sframe(sframe_w[1]), .done(done_w[1]));

  reg_serializer #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1)) dut_fast (
    .clk(clk), .rst(rst), .in_valid(in_valid_r[2]), .in_data(in_data_r[2][3:0]),
    .in_ready(in_ready_w[2]), .sout(sout_w[2]), .sframe(sframe_w[2]), .done(done_w[2]));

  typedef struct {
    int         id;
    logic [7:0] data;
    int         e;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt [3];
  int   nb [3];
  int   last_done [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int w_of(input int id);
    return (id == 2) ? 4 : 8;
  endfunction

  function automatic int d_of(input int id);
    return (id == 2) ? 1 : 4;
  endfunction

  function automatic bit msb_of(input int id);
    return id != 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the line against the frame at the head of the queue.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int   p, k, w, d;
      logic eb;
      w = w_of(i);
      d = d_of(i);
      if (rst) begin
        nb[i] = 0;
      end else begin
        if (sframe_w[i] || done_w[i]) chk("busy_ready", int'(in_ready_w[i]), 0);
        if (!sframe_w[i]) chk("sout_idle", int'(sout_w[i]), 0);
        if (last_done[i] >= 0 && cyc == last_done[i] + 1)
          chk("ready_return", int'(in_ready_w[i]), 1);
        if (sframe_w[i]) begin
          if (q.size() == 0 || q[0].id != i) begin
            chk("frame_expected", q.size(), 1);
          end else begin
            p = cyc - q[0].e;
            chk("frame_window", int'(p >= 0 && p < w * d), 1);
            if (p >= 0 && p < w * d) begin
              k  = p / d;
              eb = msb_of(i) ? q[0].data[w-1-k] : q[0].data[k];
              chk("sout_bit", int'(sout_w[i]), int'(eb));
            end
            nb[i]++;
          end
        end
        if (done_w[i]) begin
          done_cnt[i]++;
          last_done[i] = cyc;
          if (q.size() == 0 || q[0].id != i) begin
            chk("done_has_frame", q.size(), 1);
          end else begin
            chk("done_time", cyc, q[0].e + w * d);
            chk("frame_len", nb[i], w * d);
            void'(q.pop_front());
          end
          nb[i] = 0;
        end
      end
    end
  end

  // Drive a word and wait (bounded) for acceptance; returns the cycle of the first bit.
  task automatic send(input int id, input logic [7:0] d, input bit hold, output int e);
    bit got;
    got = 1'b0;
    e   = -1;
    in_data_r[id]  = d;
    in_valid_r[id] = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      #1;
      if (in_ready_w[id]) begin
        got = 1'b1;
        e   = cyc + 1;
        q.push_back('{id, d, cyc + 1});
        @(posedge clk);
        #1;
        if (!hold) in_valid_r[id] = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    chk("accept_timeout", int'(got), 1);
    if (!got) in_valid_r[id] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
    #1;
    chk("drain", q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    int e1, e2, dc;
    for (int i = 0; i < 3; i++) begin
      in_data_r[i] = '0;
      done_cnt[i]  = 0;
      nb[i]        = 0;
      last_done[i] = -10;
    end

    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready",  int'(in_ready_w[i]), 0);
      chk("rst_sframe", int'(sframe_w[i]), 0);
      chk("rst_sout",   int'(sout_w[i]), 0);
      chk("rst_done",   int'(done_w[i]), 0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk("ready_after_rst", int'(in_ready_w[i]), 1);

    // MSB-first 0xA5
    dc = done_cnt[0];
    send(0, 8'hA5, 1'b0, e1);
    drain();
    chk("a5_msb_dones", done_cnt[0] - dc, 1);

    // LSB-first 0xA5 then 0x01
    dc = done_cnt[1];
    send(1, 8'hA5, 1'b0, e1);
    drain();
    send(1, 8'h01, 1'b0, e1);
    drain();
    chk("lsb_dones", done_cnt[1] - dc, 2);

    // Back-to-back with in_data changed during the first frame
    dc = done_cnt[0];
    send(0, 8'h3C, 1'b1, e1);
    send(0, 8'hC3, 1'b0, e2);
    chk("b2b_spacing", e2 - e1, 34);
    drain();
    chk("b2b_dones", done_cnt[0] - dc, 2);

    // Reset during bit 3, then a clean 0xFF frame
    send(0, 8'h96, 1'b0, e1);
    repeat (13) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("ready_in_rst", int'(in_ready_w[0]), 0);
    @(negedge clk);
    #1;
    chk("midrst_sframe", int'(sframe_w[0]), 0);
    chk("midrst_sout",   int'(sout_w[0]), 0);
    chk("midrst_done",   int'(done_w[0]), 0);
    dc  = done_cnt[0];
    rst = 1'b0;
    q.delete();
    #1;
    chk("ready_after_midrst", int'(in_ready_w[0]), 1);
    repeat (10) @(negedge clk);
    #1;
    chk("no_done_after_rst", done_cnt[0] - dc, 0);
    send(0, 8'hFF, 1'b0, e1);
    drain();
    chk("ff_dones", done_cnt[0] - dc, 1);

    // DIV=1, WIDTH=4, 0b1001
    dc = done_cnt[2];
    send(2, 8'h09, 1'b0, e1);
    drain();
    chk("fast_dones", done_cnt[2] - dc, 1);

    // Busy protection: a 0x55 pulse during the 0x0F frame must be ignored
    dc = done_cnt[0];
    send(0, 8'h0F, 1'b0, e1);
    repeat (5) @(negedge clk);
    #1;
    in_data_r[0]  = 8'h55;
    in_valid_r[0] = 1'b1;
    @(negedge clk);
    #1;
    in_valid_r[0] = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    #1;
    chk("busy_dones", done_cnt[0] - dc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
